imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Program loader that writes the instruction memory's write port. It is the writer counterpart to the read-only fetch ports.
- Accepts a byte stream with a valid/ready handshake, assembles big-endian 32-bit words and writes them to consecutive addresses from 0.
- Holds the CPU core while loading is in progress.
- Sits between the host/debug byte source and the writable IMem.

Parameters:
- DATA_WIDTH, 32, instruction word width; fixed at 4 bytes.
- ADDR_WIDTH, 6, IMem word-address width.
- IMEM_SIZE, 64, number of IMem words; this is the maximum load length.

Ports:
- clk  input  1  system clock; rising-edge active.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a load; sampled only in IDLE.
- num_words  input  ADDR_WIDTH+1  number of words to load; sampled together with start.
- byte_in  input  8  stream data byte.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader accepts a byte this cycle.
- imem_we  output  1  IMem write enable; one-cycle pulse per word.
- imem_wa  output  ADDR_WIDTH  IMem word address.
- imem_wd  output  DATA_WIDTH  IMem write data.
- busy  output  1  high in every state except IDLE.
- cpu_hold  output  1  stalls/resets the core; equal to busy.
- done  output  1  one-cycle pulse when the load finishes.
- err  output  1  sticky error flag; cleared by the next accepted start.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE.
  - All outputs 0: imem_we, imem_wa, imem_wd, byte_ready, busy, cpu_hold, done, err.
  - Byte counter, word counter and shift register cleared.
- States: IDLE, RECV, WRITE, DONE. Add CKSUM when the optional feature is compiled in.
- IDLE:
  - byte_ready=0.
  - start=1 with 1 <= num_words <= IMEM_SIZE: latch num_words, clear err, go to RECV.
  - start=1 with num_words=0 or num_words>IMEM_SIZE: set err=1, go to DONE. No write occurs.
- RECV:
  - byte_ready=1.
  - A byte is transferred when byte_valid && byte_ready at a clk edge.
  - The shift register shifts left by 8 and inserts byte_in. The first byte of a word lands in bits [31:24].
  - On the 4th accepted byte, go to WRITE.
  - With byte_valid=0 the loader waits indefinitely; there is no timeout.
- WRITE (exactly 1 cycle):
  - byte_ready=0, imem_we=1.
  - imem_wa = word counter; imem_wd = assembled word.
  - Next state:
    - If the word counter equals latched num_words-1: go to DONE, or to CKSUM if enabled.
    - Otherwise increment the word counter and return to RECV.
  - Write latency: 1 cycle after the 4th byte handshake.
- DONE (1 cycle): done=1, busy=1, then go to IDLE.
- imem_we is 0 in every state except WRITE. imem_wa and imem_wd hold their last values outside WRITE.
- start is ignored in every state except IDLE.
- busy and cpu_hold are combinationally equal to (state != IDLE).
- Boundary conditions:
  - num_words=IMEM_SIZE: last write at address IMEM_SIZE-1; the word counter never wraps.
  - Reset mid-load: return to IDLE immediately. A partially assembled word is discarded and never written. Words already written stay in IMem.
  - start and rst in the same cycle: rst wins.

Optional Feature:
- Macro: IMEM_LOADER_CKSUM_EN.
- When defined:
  - An 8-bit running sum (modulo 256) accumulates every accepted data byte.
  - After the last WRITE, enter CKSUM: byte_ready=1, wait for one checksum byte.
  - If (sum + checksum_byte) mod 256 != 0, set err=1.
  - Then go to DONE.
  - Written words are never rolled back.
- When undefined:
  - No CKSUM state and no sum register.
  - err is set only for an illegal num_words.

Decomposition:
- Shared package/header `imem_pkg` holds:
  - DATA_WIDTH, ADDR_WIDTH, IMEM_SIZE constants;
  - the loader state encoding (IDLE=0, RECV=1, WRITE=2, DONE=3, CKSUM=4).
- One natural sub-module: `byte_word_packer`. It is the 4-byte shift register plus byte counter, with a word_ready pulse.
- The FSM, counters and the checksum stay in the top module.

Test Plan:
1. rst, then start with num_words=2 and bytes 34 08 00 05 3C 0D 12 34 → writes (wa=0, wd=34080005), then (wa=1, wd=3C0D1234). done pulses once; busy returns to 0.
2. Insert byte_valid gaps of 0–5 cycles between bytes (random) → identical writes. byte_ready never drops in RECV.
3. start with num_words=0, and separately with num_words=65 → no imem_we. err=1, done pulses; the next legal start clears err.
4. num_words=64 → 64 writes at addresses 0..63, each word = address replicated in all 4 bytes. No write to address 0 after address 63.
5. Assert rst after 2 bytes of word 1 in a 3-word load → no further writes and state=IDLE. A fresh load then succeeds from address 0.
6. With IMEM_LOADER_CKSUM_EN and 1 word 00 00 00 01: checksum FF → err=0; checksum 00 → err=1. The word is written in both cases.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared constants and FSM encoding for the instruction-memory loader.
// The optional checksum state is used only when IMEM_LOADER_CKSUM_EN is defined.
package imem_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 6;
  localparam int IMEM_SIZE  = 64;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RECV  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_CKSUM = 3'd4;

  // A load length is legal when it is 1..IMEM_SIZE words.
  function automatic logic len_ok(input logic [ADDR_WIDTH:0] n);
    return (n != '0) && (n <= (ADDR_WIDTH + 1)'(IMEM_SIZE));
  endfunction

endpackage

// File: rtl/imem_loader_byte_word_packer.sv
// Big-endian byte-to-word assembler: 4-byte shift register plus byte counter.
// o_word_ready flags the handshake that delivers the 4th byte of a word.
module byte_word_packer
  import imem_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_shift_en,
  input  logic [7:0]            i_byte,
  output logic [DATA_WIDTH-1:0] o_word,
  output logic                  o_word_ready
);

  logic [1:0]            r_cnt;
  logic [DATA_WIDTH-1:0] r_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= 2'd0;
      r_word <= '0;
    end else if (i_shift_en) begin
      r_word <= {r_word[DATA_WIDTH-9:0], i_byte};
      r_cnt  <= r_cnt + 2'd1;
    end
  end

  assign o_word       = r_word;
  assign o_word_ready = i_shift_en && (r_cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader driving the IMem write port and holding the core.
// Define IMEM_LOADER_CKSUM_EN to require a trailing modulo-256 checksum byte.
module imem_loader
  import imem_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   num_words,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_wa,
  output logic [DATA_WIDTH-1:0] imem_wd,
  output logic                  busy,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  err
);

  logic [2:0]            r_state;
  logic [ADDR_WIDTH:0]   r_num;
  logic [ADDR_WIDTH-1:0] r_wcnt;
  logic [ADDR_WIDTH-1:0] r_wa;
  logic [DATA_WIDTH-1:0] r_wd;
  logic                  r_err;
`ifdef IMEM_LOADER_CKSUM_EN
  logic [7:0]            r_sum;
`endif

  logic                  w_accept;
  logic                  w_shift;
  logic                  w_word_ready;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_word;

  assign w_accept = byte_valid && byte_ready;
  assign w_shift  = w_accept && (r_state == ST_RECV);
  assign w_last   = ({1'b0, r_wcnt} == (r_num - (ADDR_WIDTH + 1)'(1)));

  byte_word_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .i_shift_en   (w_shift),
    .i_byte       (byte_in),
    .o_word       (w_word),
    .o_word_ready (w_word_ready)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_num   <= '0;
      r_wcnt  <= '0;
      r_wa    <= '0;
      r_wd    <= '0;
      r_err   <= 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
      r_sum   <= 8'd0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (len_ok(num_words)) begin
              r_num   <= num_words;
              r_wcnt  <= '0;
              r_err   <= 1'b0;
              r_state <= ST_RECV;
`ifdef IMEM_LOADER_CKSUM_EN
              r_sum   <= 8'd0;
`endif
            end else begin
              r_err   <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_RECV: begin
`ifdef IMEM_LOADER_CKSUM_EN
          if (w_accept) r_sum <= r_sum + byte_in;
`endif
          if (w_word_ready) r_state <= ST_WRITE;
        end
        ST_WRITE: begin
          // Keep the written address/data visible after the pulse ends.
          r_wa <= r_wcnt;
          r_wd <= w_word;
          if (w_last) begin
`ifdef IMEM_LOADER_CKSUM_EN
            r_state <= ST_CKSUM;
`else
            r_state <= ST_DONE;
`endif
          end else begin
            r_wcnt  <= r_wcnt + 1'b1;
            r_state <= ST_RECV;
          end
        end
`ifdef IMEM_LOADER_CKSUM_EN
        ST_CKSUM: begin
          if (w_accept) begin
            if (8'(r_sum + byte_in) != 8'd0) r_err <= 1'b1;
            r_state <= ST_DONE;
          end
        end
`endif
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef IMEM_LOADER_CKSUM_EN
  assign byte_ready = (r_state == ST_RECV) || (r_state == ST_CKSUM);
`else
  assign byte_ready = (r_state == ST_RECV);
`endif

  assign imem_we  = (r_state == ST_WRITE);
  assign imem_wa  = imem_we ? r_wcnt : r_wa;
  assign imem_wd  = imem_we ? w_word : r_wd;
  assign busy     = (r_state != ST_IDLE);
  assign cpu_hold = busy;
  assign done     = (r_state == ST_DONE);
  assign err      = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected writes/done events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [6:0] num_words;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic       imem_we;
  logic [5:0] imem_wa;
  logic [31:0] imem_wd;
  logic       busy;
  logic       cpu_hold;
  logic       done;
  logic       err;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t  exp_wq[$];
  bit   exp_dq[$];
  logic [7:0] data [0:255];
  int   vectors = 0;
  int   miss    = 0;

  always #5 clk = ~clk;

  imem_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_words  (num_words),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_wa    (imem_wa),
    .imem_wd    (imem_wd),
    .busy       (busy),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every write and done pulse against the expectation queues.
  always @(negedge clk) begin
    wr_t e;
    if (imem_we === 1'b1) begin
      if (exp_wq.size() == 0) begin
        vectors++;
        miss++;
        $display("FAIL unexpected_write: wa=%0d wd=%h, expected no write", imem_wa, imem_wd);
      end else begin
        e = exp_wq.pop_front();
        chk("write_addr", 32'(imem_wa), 32'(e.addr));
        chk("write_data", imem_wd, e.data);
      end
    end
    if (done === 1'b1) begin
      if (exp_dq.size() == 0) begin
        vectors++;
        miss++;
        $display("FAIL unexpected_done: done=1, expected 0");
      end else begin
        chk("done_err", 32'(err), 32'(exp_dq.pop_front()));
        chk("done_busy", 32'(busy), 32'd1);
      end
    end
    if (cpu_hold !== busy) chk("hold_eq_busy", 32'(cpu_hold), 32'(busy));
  end

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_we",    32'(imem_we),    32'd0);
    chk("rst_wa",    32'(imem_wa),    32'd0);
    chk("rst_wd",    imem_wd,         32'd0);
    chk("rst_ready", 32'(byte_ready), 32'd0);
    chk("rst_busy",  32'(busy),       32'd0);
    chk("rst_hold",  32'(cpu_hold),   32'd0);
    chk("rst_done",  32'(done),       32'd0);
    chk("rst_err",   32'(err),        32'd0);
  endtask

  task automatic do_start(input logic [6:0] n);
    start = 1'b1; num_words = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit midword);
    int n;
    for (int g = 0; g < gap; g++) begin
      byte_valid = 1'b0;
      byte_in = 8'($urandom);
      @(negedge clk);
      if (midword) chk("ready_in_gap", 32'(byte_ready), 32'd1);
    end
    byte_valid = 1'b1; byte_in = b;
    n = 0;
    while (byte_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n == 100) chk("ready_timeout", 32'(byte_ready), 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n == 100) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Reference model: word i is bytes 4i..4i+3 big-endian, written to address i.
  task automatic run_load(input int n, input int gmax, input bit bad_ck);
    wr_t w;
    logic [7:0] sum;
    sum = 8'd0;
    for (int i = 0; i < n; i++) begin
      w.addr = 6'(i);
      w.data = {data[4*i], data[4*i+1], data[4*i+2], data[4*i+3]};
      exp_wq.push_back(w);
    end
`ifdef IMEM_LOADER_CKSUM_EN
    exp_dq.push_back(bad_ck);
`else
    exp_dq.push_back(1'b0);
`endif
    do_start(7'(n));
    chk("err_cleared", 32'(err), 32'd0);
    for (int i = 0; i < 4*n; i++) begin
      send_byte(data[i], (gmax == 0) ? 0 : int'($urandom_range(gmax, 0)), (i % 4) != 0);
      sum = sum + data[i];
    end
`ifdef IMEM_LOADER_CKSUM_EN
    send_byte(bad_ck ? 8'(8'd1 - sum) : 8'(8'd0 - sum), 0, 1'b0);
`endif
    wait_idle();
    chk("writes_drained", 32'(exp_wq.size()), 32'd0);
    chk("done_seen", 32'(exp_dq.size()), 32'd0);
  endtask

  task automatic bad_len(input logic [6:0] n);
    exp_dq.push_back(1'b1);
    do_start(n);
    wait_idle();
    chk("bad_len_err", 32'(err), 32'd1);
    chk("bad_len_done", 32'(exp_dq.size()), 32'd0);
  endtask

  initial begin
    wr_t w;
    int  nw;
    rst = 1'b1; start = 1'b0; num_words = '0; byte_in = '0; byte_valid = 1'b0;
    @(negedge clk);
    do_reset();

    // Directed two-word load.
    data[0] = 8'h34; data[1] = 8'h08; data[2] = 8'h00; data[3] = 8'h05;
    data[4] = 8'h3C; data[5] = 8'h0D; data[6] = 8'h12; data[7] = 8'h34;
    run_load(2, 0, 1'b0);
    chk("busy_after", 32'(busy), 32'd0);
    chk("wa_held", 32'(imem_wa), 32'd1);
    chk("wd_held", imem_wd, 32'h3C0D1234);

    // Random lengths and data with handshake gaps.
    for (int t = 0; t < 4; t++) begin
      nw = int'($urandom_range(8, 1));
      for (int i = 0; i < 4*nw; i++) data[i] = 8'($urandom);
      run_load(nw, 5, 1'b0);
    end

    // Illegal lengths, then a legal load clears err.
    bad_len(7'd0);
    bad_len(7'd65);
    for (int i = 0; i < 4; i++) data[i] = 8'($urandom);
    run_load(1, 2, 1'b0);
    chk("err_after_legal", 32'(err), 32'd0);

    // Full-size load: each word is its address replicated in all bytes.
    for (int i = 0; i < 256; i++) data[i] = 8'(i / 4);
    run_load(64, 0, 1'b0);
    repeat (3) @(negedge clk);

    // Reset mid-load after two bytes of word 1.
    for (int i = 0; i < 12; i++) data[i] = 8'($urandom_range(255, 1));
    w.addr = 6'd0;
    w.data = {data[0], data[1], data[2], data[3]};
    exp_wq.push_back(w);
    do_start(7'd3);
    for (int i = 0; i < 6; i++) send_byte(data[i], 0, (i % 4) != 0);
    do_reset();
    repeat (6) @(negedge clk);
    chk("midload_idle", 32'(busy), 32'd0);
    chk("midload_writes", 32'(exp_wq.size()), 32'd0);
    run_load(3, 1, 1'b0);

    // start together with rst: reset wins.
    rst = 1'b1; start = 1'b1; num_words = 7'd3;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_wins", 32'(busy), 32'd0);

`ifdef IMEM_LOADER_CKSUM_EN
    data[0] = 8'h00; data[1] = 8'h00; data[2] = 8'h00; data[3] = 8'h01;
    run_load(1, 0, 1'b0);
    chk("ck_good_err", 32'(err), 32'd0);
    run_load(1, 0, 1'b1);
    chk("ck_bad_err", 32'(err), 32'd1);
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
